// File: rtl/io_mmio_controller_pkg.sv
// io_mmio_controller_pkg: region tag, register offsets and status bit positions for the IO block.
package io_mmio_controller_pkg;
  localparam logic [1:0] IO_REGION    = 2'b10;
  localparam logic [7:0] IO_UART_CTRL = 8'h00;
  localparam logic [7:0] IO_UART_RX   = 8'h04;
  localparam logic [7:0] IO_UART_TX   = 8'h08;
  localparam logic [7:0] IO_CYC_CNT   = 8'h10;
  localparam logic [7:0] IO_INSTR_CNT = 8'h14;
  localparam logic [7:0] IO_CNT_RST   = 8'h18;
  localparam int ST_TX_READY = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_TX_OVF   = 2;
  localparam int ST_RX_OVF   = 3;
endpackage

// File: rtl/io_mmio_controller_fifo.sv
// io_fifo: synchronous FIFO with a combinational head; push is accepted at full when a pop shares the edge.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty   = wp == rp;
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_push);
      rp <= rp + (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/io_mmio_controller.sv
// io_mmio_controller: MMIO decode, UART TX/RX buffering, cycle/instret counters, one-cycle registered reads.
module io_mmio_controller
  import io_mmio_controller_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  input  logic        instr_retire,
  output logic [7:0]  uart_tx_data_in,
  output logic        uart_tx_data_in_valid,
  input  logic        uart_tx_data_in_ready,
  input  logic [7:0]  uart_rx_data_out,
  input  logic        uart_rx_data_out_valid,
  output logic        uart_rx_data_out_ready
);
  logic active, rd, wr, st_rd, cnt_clr;
  logic [7:0] off, rx_head;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_ovf, rx_ovf;
  logic [31:0] cyc_cnt, instr_cnt, status, rd_val;
  logic unused;
  assign unused  = ^{req_addr[29:8], req_wdata[31:8]};
  assign active  = req_valid && (req_addr[31:30] == IO_REGION);
  assign off     = req_addr[7:0];
  assign rd      = active && !req_we;
  assign wr      = active && req_we;
  assign st_rd   = rd && (off == IO_UART_CTRL);
  assign cnt_clr = wr && (off == IO_CNT_RST);
  assign tx_push = wr && (off == IO_UART_TX);
  assign tx_pop  = uart_tx_data_in_valid && uart_tx_data_in_ready;
  assign rx_push = uart_rx_data_out_valid && uart_rx_data_out_ready;
  assign rx_pop  = rd && (off == IO_UART_RX) && !rx_empty;
  assign uart_tx_data_in_valid  = !tx_empty;
  assign uart_rx_data_out_ready = !rst;
  always_comb begin
    status = '0;
    status[ST_TX_READY] = !tx_full;
    status[ST_RX_VALID] = !rx_empty;
    status[ST_TX_OVF]   = tx_ovf;
    status[ST_RX_OVF]   = rx_ovf;
    rd_val = off == IO_UART_CTRL ? status :
             off == IO_UART_RX   ? {24'b0, rx_empty ? 8'h00 : rx_head} :
             off == IO_CYC_CNT   ? cyc_cnt :
             off == IO_INSTR_CNT ? instr_cnt : '0;
  end
  io_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(req_wdata[7:0]),
    .dout(uart_tx_data_in), .full(tx_full), .empty(tx_empty)
  );
  io_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(uart_rx_data_out),
    .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );
  // Overflow only when the FIFO stays full across the edge; a set beats a same-edge status clear.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
      cyc_cnt   <= '0;
      instr_cnt <= '0;
      rdata     <= '0;
    end else begin
      tx_ovf    <= (tx_push && tx_full && !tx_pop) || (tx_ovf && !st_rd);
      rx_ovf    <= (rx_push && rx_full && !rx_pop) || (rx_ovf && !st_rd);
      cyc_cnt   <= cnt_clr ? '0 : cyc_cnt + 32'd1;
      instr_cnt <= cnt_clr ? '0 : instr_cnt + 32'(instr_retire);
      if (rd) rdata <= rd_val;
    end
endmodule

// File: tb/tb_io_mmio_controller.sv
// tb_io_mmio_controller: directed plus random stimulus checked against a queue-based model of the register map.
module tb_io_mmio_controller;
  localparam int TX_DEPTH = 8;
  localparam int RX_DEPTH = 8;
  logic clk = 0, rst = 0;
  logic req_valid = 0, req_we = 0, instr_retire = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, rdata;
  logic [7:0] uart_tx_data_in, uart_rx_data_out = 0;
  logic uart_tx_data_in_valid, uart_tx_data_in_ready = 0;
  logic uart_rx_data_out_valid = 0, uart_rx_data_out_ready;
  int checks = 0, errors = 0;
  logic [7:0] m_tx[$], m_rx[$];
  logic [31:0] m_cyc, m_ins, m_rdata;
  bit m_txovf, m_rxovf;
  logic [31:0] addrs [7] = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h14, 32'h18, 32'h20};

  io_mmio_controller #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .rdata(rdata), .instr_retire(instr_retire),
    .uart_tx_data_in(uart_tx_data_in), .uart_tx_data_in_valid(uart_tx_data_in_valid),
    .uart_tx_data_in_ready(uart_tx_data_in_ready), .uart_rx_data_out(uart_rx_data_out),
    .uart_rx_data_out_valid(uart_rx_data_out_valid), .uart_rx_data_out_ready(uart_rx_data_out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit rdop, wrop;
    logic [7:0] o;
    rdop = req_valid && req_addr[31:30] == 2'b10 && !req_we;
    wrop = req_valid && req_addr[31:30] == 2'b10 && req_we;
    o = req_addr[7:0];
    if (rdop)
      m_rdata = o == 8'h00 ? {28'b0, m_rxovf, m_txovf, m_rx.size() != 0, m_tx.size() < TX_DEPTH} :
                o == 8'h04 ? (m_rx.size() != 0 ? {24'b0, m_rx[0]} : 32'h0) :
                o == 8'h10 ? m_cyc : o == 8'h14 ? m_ins : 32'h0;
    if (m_tx.size() != 0 && uart_tx_data_in_ready) void'(m_tx.pop_front());
    if (rdop && o == 8'h04 && m_rx.size() != 0) void'(m_rx.pop_front());
    if (rdop && o == 8'h00) begin m_txovf = 0; m_rxovf = 0; end
    if (wrop && o == 8'h08) begin
      if (m_tx.size() < TX_DEPTH) m_tx.push_back(req_wdata[7:0]); else m_txovf = 1;
    end
    if (uart_rx_data_out_valid) begin
      if (m_rx.size() < RX_DEPTH) m_rx.push_back(uart_rx_data_out); else m_rxovf = 1;
    end
    if (wrop && o == 8'h18) begin m_cyc = 0; m_ins = 0; end
    else begin m_cyc++; m_ins += 32'(instr_retire); end
    @(posedge clk);
    #1;
    check("rdata", rdata, m_rdata);
    check("tx_valid", 32'(uart_tx_data_in_valid), 32'(m_tx.size() != 0));
    if (m_tx.size() != 0) check("tx_data", 32'(uart_tx_data_in), 32'(m_tx[0]));
    check("rx_ready", 32'(uart_rx_data_out_ready), 32'h1);
  endtask

  task automatic acc(bit we, logic [31:0] a, logic [31:0] d);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    tick();
    req_valid = 0; req_we = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    m_tx.delete(); m_rx.delete();
    m_cyc = 0; m_ins = 0; m_rdata = 0; m_txovf = 0; m_rxovf = 0;
    #1;
    check("rst_tx_valid", 32'(uart_tx_data_in_valid), 32'h0);
    check("rst_rx_ready", 32'(uart_rx_data_out_ready), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    logic [7:0] b;
    @(posedge clk); #1;
    do_reset();
    acc(0, 32'h8000_0010, 0);
    check("cyc_after_rst", rdata, 32'h0);
    acc(0, 32'h8000_0000, 0);
    check("status_rst", rdata, 32'h1);
    acc(0, 32'h8000_0014, 0);
    check("instr_after_rst", rdata, 32'h0);
    // TX ordering with ready held low, then drained
    uart_tx_data_in_ready = 0;
    acc(1, 32'h8000_0008, 32'h41);
    acc(1, 32'h8000_0008, 32'h42);
    tick();
    uart_tx_data_in_ready = 1;
    repeat (3) tick();
    // RX single byte
    b = 8'($urandom);
    uart_rx_data_out = b; uart_rx_data_out_valid = 1;
    tick();
    uart_rx_data_out_valid = 0;
    acc(0, 32'h8000_0004, 0);
    check("rx_byte", rdata, {24'b0, b});
    acc(0, 32'h8000_0000, 0);
    acc(0, 32'h8000_0004, 0);
    check("rx_empty_read", rdata, 32'h0);
    // TX overflow and read-to-clear
    uart_tx_data_in_ready = 0;
    repeat (9) acc(1, 32'h8000_0008, $urandom);
    acc(0, 32'h8000_0000, 0);
    check("status_tx_ovf", rdata, 32'h4);
    acc(0, 32'h8000_0000, 0);
    uart_tx_data_in_ready = 1;
    repeat (10) tick();
    // counters
    acc(1, 32'h8000_0018, 0);
    instr_retire = 1;
    repeat (5) tick();
    instr_retire = 0;
    acc(0, 32'h8000_0014, 0);
    check("instr_five", rdata, 32'h5);
    instr_retire = 1;
    acc(1, 32'h8000_0018, 0);
    instr_retire = 0;
    acc(0, 32'h8000_0014, 0);
    check("instr_cleared", rdata, 32'h0);
    acc(0, 32'h8000_0010, 0);
    // RX full: same-edge push and pop
    for (int i = 0; i < RX_DEPTH; i++) begin
      uart_rx_data_out = 8'($urandom); uart_rx_data_out_valid = 1;
      tick();
    end
    uart_rx_data_out = 8'($urandom);
    acc(0, 32'h8000_0004, 0);
    uart_rx_data_out_valid = 0;
    acc(0, 32'h8000_0000, 0);
    check("rx_full_no_ovf", rdata & 32'h8, 32'h0);
    acc(0, 32'h8000_0020, 0);
    check("unmapped", rdata, 32'h0);
    // random traffic, including out-of-region accesses
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom);
      req_we = 1'($urandom);
      req_addr = addrs[$urandom_range(6)];
      req_addr[31:30] = ($urandom_range(3) != 0) ? 2'b10 : 2'($urandom);
      req_wdata = $urandom;
      instr_retire = 1'($urandom);
      uart_tx_data_in_ready = ($urandom_range(3) == 0);
      uart_rx_data_out_valid = 1'($urandom);
      uart_rx_data_out = 8'($urandom);
      tick();
    end
    req_valid = 0; uart_rx_data_out_valid = 0; instr_retire = 0;
    do_reset();
    acc(0, 32'h8000_0000, 0);
    check("status_after_rst2", rdata, 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
